// File: rtl/axi_lite_reg_cut.sv
// axi_lite_reg_cut: AXI4-Lite pipeline cut, one two-slot spill register per channel.
//   clk_i, rst_ni         : clock, asynchronous active-low reset
//   in_aw/in_w/in_ar      : master-side request channels (sink of this block's inputs)
//   in_b/in_r             : master-side response channels
//   out_aw/out_w/out_ar   : slave-side request channels
//   out_b/out_r           : slave-side response channels
//   BYPASS=1              : pure wire-through, no state

module axi_lite_reg_cut_spill #(
    parameter int unsigned WIDTH  = 8,
    parameter bit          BYPASS = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] src_data_i,
    input  logic             src_valid_i,
    output logic             src_ready_o,
    output logic [WIDTH-1:0] dst_data_o,
    output logic             dst_valid_o,
    input  logic             dst_ready_i
);
    if (BYPASS) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;
        assign dst_data_o     = src_data_i;
        assign dst_valid_o    = src_valid_i;
        assign src_ready_o    = dst_ready_i;
    end else begin : g_spill
        logic             a_full_q, a_full_d, b_full_q, b_full_d;
        logic [WIDTH-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
        logic             src_hs, a_free;
        always_comb begin
            src_hs   = src_valid_i & ~b_full_q;
            a_free   = ~a_full_q | dst_ready_i;
            a_full_d = a_full_q;
            a_data_d = a_data_q;
            b_full_d = b_full_q;
            b_data_d = b_data_q;
            if (a_free) begin
                // B holds the older beat, so it always refills A first
                a_full_d = b_full_q | src_hs;
                a_data_d = b_full_q ? b_data_q : (src_hs ? src_data_i : a_data_q);
                b_full_d = 1'b0;
            end else if (src_hs) begin
                b_full_d = 1'b1;
                b_data_d = src_data_i;
            end
        end
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                a_full_q <= 1'b0;
                b_full_q <= 1'b0;
                a_data_q <= '0;
                b_data_q <= '0;
            end else begin
                a_full_q <= a_full_d;
                b_full_q <= b_full_d;
                a_data_q <= a_data_d;
                b_data_q <= b_data_d;
            end
        end
        assign src_ready_o = ~b_full_q;
        assign dst_valid_o = a_full_q;
        assign dst_data_o  = a_data_q;
    end
endmodule

module axi_lite_reg_cut #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter bit          BYPASS     = 1'b0
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [ADDR_WIDTH-1:0]   in_aw_addr,
    input  logic                    in_aw_valid,
    output logic                    in_aw_ready,
    input  logic [DATA_WIDTH-1:0]   in_w_data,
    input  logic [DATA_WIDTH/8-1:0] in_w_strb,
    input  logic                    in_w_valid,
    output logic                    in_w_ready,
    output logic [1:0]              in_b_resp,
    output logic                    in_b_valid,
    input  logic                    in_b_ready,
    input  logic [ADDR_WIDTH-1:0]   in_ar_addr,
    input  logic                    in_ar_valid,
    output logic                    in_ar_ready,
    output logic [DATA_WIDTH-1:0]   in_r_data,
    output logic [1:0]              in_r_resp,
    output logic                    in_r_valid,
    input  logic                    in_r_ready,
    output logic [ADDR_WIDTH-1:0]   out_aw_addr,
    output logic                    out_aw_valid,
    input  logic                    out_aw_ready,
    output logic [DATA_WIDTH-1:0]   out_w_data,
    output logic [DATA_WIDTH/8-1:0] out_w_strb,
    output logic                    out_w_valid,
    input  logic                    out_w_ready,
    input  logic [1:0]              out_b_resp,
    input  logic                    out_b_valid,
    output logic                    out_b_ready,
    output logic [ADDR_WIDTH-1:0]   out_ar_addr,
    output logic                    out_ar_valid,
    input  logic                    out_ar_ready,
    input  logic [DATA_WIDTH-1:0]   out_r_data,
    input  logic [1:0]              out_r_resp,
    input  logic                    out_r_valid,
    output logic                    out_r_ready
);
    localparam int unsigned SW = DATA_WIDTH / 8;

    if (DATA_WIDTH % 8 != 0) begin : g_bad_data_width
        $error("axi_lite_reg_cut: DATA_WIDTH must be a multiple of 8");
    end
    if (ADDR_WIDTH == 0) begin : g_bad_addr_width
        $error("axi_lite_reg_cut: ADDR_WIDTH must be greater than 0");
    end

    axi_lite_reg_cut_spill #(.WIDTH(ADDR_WIDTH), .BYPASS(BYPASS)) u_aw (
        .clk_i, .rst_ni,
        .src_data_i(in_aw_addr),   .src_valid_i(in_aw_valid),  .src_ready_o(in_aw_ready),
        .dst_data_o(out_aw_addr),  .dst_valid_o(out_aw_valid), .dst_ready_i(out_aw_ready)
    );

    axi_lite_reg_cut_spill #(.WIDTH(DATA_WIDTH + SW), .BYPASS(BYPASS)) u_w (
        .clk_i, .rst_ni,
        .src_data_i({in_w_strb, in_w_data}),   .src_valid_i(in_w_valid),  .src_ready_o(in_w_ready),
        .dst_data_o({out_w_strb, out_w_data}), .dst_valid_o(out_w_valid), .dst_ready_i(out_w_ready)
    );

    axi_lite_reg_cut_spill #(.WIDTH(2), .BYPASS(BYPASS)) u_b (
        .clk_i, .rst_ni,
        .src_data_i(out_b_resp), .src_valid_i(out_b_valid), .src_ready_o(out_b_ready),
        .dst_data_o(in_b_resp),  .dst_valid_o(in_b_valid),  .dst_ready_i(in_b_ready)
    );

    axi_lite_reg_cut_spill #(.WIDTH(ADDR_WIDTH), .BYPASS(BYPASS)) u_ar (
        .clk_i, .rst_ni,
        .src_data_i(in_ar_addr),  .src_valid_i(in_ar_valid),  .src_ready_o(in_ar_ready),
        .dst_data_o(out_ar_addr), .dst_valid_o(out_ar_valid), .dst_ready_i(out_ar_ready)
    );

    axi_lite_reg_cut_spill #(.WIDTH(DATA_WIDTH + 2), .BYPASS(BYPASS)) u_r (
        .clk_i, .rst_ni,
        .src_data_i({out_r_resp, out_r_data}), .src_valid_i(out_r_valid), .src_ready_o(out_r_ready),
        .dst_data_o({in_r_resp, in_r_data}),   .dst_valid_o(in_r_valid),  .dst_ready_i(in_r_ready)
    );
endmodule

// File: tb/tb_axi_lite_reg_cut.sv
// tb_axi_lite_reg_cut: randomized scoreboard bench for axi_lite_reg_cut.
// Channels are indexed 0=AW 1=W 2=AR 3=B 4=R; each is modelled as an
// in-order FIFO of at most two beats whose head is visible at the sink.
module tb_axi_lite_reg_cut;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [39:0] sd [5];
    logic        sv [5];
    logic        kr [5];
    wire  [39:0] kd [5];
    wire         kv [5];
    wire         sr [5];

    int passed = 0;
    int total  = 0;

    logic [39:0] stim [5][2048];
    int          s_wr [5];
    int          s_rd [5];
    logic [39:0] exp_m [5][8];
    int          e_wr [5];
    int          e_rd [5];
    int          dlv [5];
    int          pv [5];
    int          pr [5];

    wire [31:0] out_aw_addr, out_ar_addr, out_w_data, in_r_data;
    wire [3:0]  out_w_strb;
    wire [1:0]  in_b_resp, in_r_resp;
    wire        out_aw_valid, out_w_valid, out_ar_valid, in_b_valid, in_r_valid;
    wire        in_aw_ready, in_w_ready, in_ar_ready, out_b_ready, out_r_ready;

    axi_lite_reg_cut dut (
        .clk_i(clk), .rst_ni(rst_n),
        .in_aw_addr(sd[0][31:0]), .in_aw_valid(sv[0]), .in_aw_ready(in_aw_ready),
        .in_w_data(sd[1][31:0]), .in_w_strb(sd[1][35:32]), .in_w_valid(sv[1]), .in_w_ready(in_w_ready),
        .in_b_resp(in_b_resp), .in_b_valid(in_b_valid), .in_b_ready(kr[3]),
        .in_ar_addr(sd[2][31:0]), .in_ar_valid(sv[2]), .in_ar_ready(in_ar_ready),
        .in_r_data(in_r_data), .in_r_resp(in_r_resp), .in_r_valid(in_r_valid), .in_r_ready(kr[4]),
        .out_aw_addr(out_aw_addr), .out_aw_valid(out_aw_valid), .out_aw_ready(kr[0]),
        .out_w_data(out_w_data), .out_w_strb(out_w_strb), .out_w_valid(out_w_valid), .out_w_ready(kr[1]),
        .out_b_resp(sd[3][1:0]), .out_b_valid(sv[3]), .out_b_ready(out_b_ready),
        .out_ar_addr(out_ar_addr), .out_ar_valid(out_ar_valid), .out_ar_ready(kr[2]),
        .out_r_data(sd[4][31:0]), .out_r_resp(sd[4][33:32]), .out_r_valid(sv[4]), .out_r_ready(out_r_ready)
    );

    assign kd[0] = {8'b0, out_aw_addr};
    assign kd[1] = {4'b0, out_w_strb, out_w_data};
    assign kd[2] = {8'b0, out_ar_addr};
    assign kd[3] = {38'b0, in_b_resp};
    assign kd[4] = {6'b0, in_r_resp, in_r_data};
    assign kv[0] = out_aw_valid;
    assign kv[1] = out_w_valid;
    assign kv[2] = out_ar_valid;
    assign kv[3] = in_b_valid;
    assign kv[4] = in_r_valid;
    assign sr[0] = in_aw_ready;
    assign sr[1] = in_w_ready;
    assign sr[2] = in_ar_ready;
    assign sr[3] = out_b_ready;
    assign sr[4] = out_r_ready;

    wire [31:0] b_out_aw_addr, b_out_ar_addr, b_out_w_data, b_in_r_data;
    wire [3:0]  b_out_w_strb;
    wire [1:0]  b_in_b_resp, b_in_r_resp;
    wire        b_out_aw_valid, b_out_w_valid, b_out_ar_valid, b_in_b_valid, b_in_r_valid;
    wire        b_in_aw_ready, b_in_w_ready, b_in_ar_ready, b_out_b_ready, b_out_r_ready;

    axi_lite_reg_cut #(.BYPASS(1'b1)) dut_byp (
        .clk_i(clk), .rst_ni(rst_n),
        .in_aw_addr(sd[0][31:0]), .in_aw_valid(sv[0]), .in_aw_ready(b_in_aw_ready),
        .in_w_data(sd[1][31:0]), .in_w_strb(sd[1][35:32]), .in_w_valid(sv[1]), .in_w_ready(b_in_w_ready),
        .in_b_resp(b_in_b_resp), .in_b_valid(b_in_b_valid), .in_b_ready(kr[3]),
        .in_ar_addr(sd[2][31:0]), .in_ar_valid(sv[2]), .in_ar_ready(b_in_ar_ready),
        .in_r_data(b_in_r_data), .in_r_resp(b_in_r_resp), .in_r_valid(b_in_r_valid), .in_r_ready(kr[4]),
        .out_aw_addr(b_out_aw_addr), .out_aw_valid(b_out_aw_valid), .out_aw_ready(kr[0]),
        .out_w_data(b_out_w_data), .out_w_strb(b_out_w_strb), .out_w_valid(b_out_w_valid), .out_w_ready(kr[1]),
        .out_b_resp(sd[3][1:0]), .out_b_valid(sv[3]), .out_b_ready(b_out_b_ready),
        .out_ar_addr(b_out_ar_addr), .out_ar_valid(b_out_ar_valid), .out_ar_ready(kr[2]),
        .out_r_data(sd[4][31:0]), .out_r_resp(sd[4][33:32]), .out_r_valid(sv[4]), .out_r_ready(b_out_r_ready)
    );

    function automatic logic [39:0] mask(input int ch);
        case (ch)
            1:       return 40'h0F_FFFF_FFFF;
            3:       return 40'h00_0000_0003;
            4:       return 40'h03_FFFF_FFFF;
            default: return 40'h00_FFFF_FFFF;
        endcase
    endfunction

    task automatic chk(input string n, input int ch, input logic [39:0] act, input logic [39:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s ch%0d: got %h expected %h", n, ch, act, exp);
    endtask

    task automatic send(input int ch, input logic [39:0] d);
        stim[ch][s_wr[ch] % 2048] = d & mask(ch);
        s_wr[ch]++;
    endtask

    task automatic all_pv(input int p);
        for (int i = 0; i < 5; i++) pv[i] = p;
    endtask

    // Driver: presents the next queued beat per channel; a source handshake
    // observed mid-cycle is committed to the expected FIFO at the next edge.
    initial begin
        logic hs [5];
        for (int i = 0; i < 5; i++) begin
            hs[i] = 1'b0;
            sv[i] = 1'b0;
            sd[i] = '0;
            kr[i] = 1'b1;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 5; i++) begin
                if (hs[i] && rst_n) begin
                    if (e_wr[i] - e_rd[i] >= 8) $display("FAIL model_overflow ch%0d: got %0d expected <8", i, e_wr[i] - e_rd[i]);
                    exp_m[i][e_wr[i] % 8] = sd[i];
                    e_wr[i]++;
                    s_rd[i]++;
                end
                hs[i] = 1'b0;
            end
            #1;
            for (int i = 0; i < 5; i++) begin
                sv[i] = (s_rd[i] < s_wr[i]) && ($urandom_range(99) < pv[i]);
                sd[i] = (s_rd[i] < s_wr[i]) ? stim[i][s_rd[i] % 2048] : '0;
                kr[i] = $urandom_range(99) < pr[i];
            end
            @(negedge clk);
            for (int i = 0; i < 5; i++) hs[i] = sv[i] && sr[i];
        end
    end

    // Monitor: compares sink valid/payload and source ready against the FIFO model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                for (int i = 0; i < 5; i++) begin
                    int occ;
                    occ = e_wr[i] - e_rd[i];
                    chk("sink_valid", i, {39'b0, kv[i]}, {39'b0, occ > 0});
                    chk("src_ready", i, {39'b0, sr[i]}, {39'b0, occ < 2});
                    if (occ > 0) chk("sink_data", i, kd[i], exp_m[i][e_rd[i] % 8]);
                    if (kv[i] && kr[i] && occ > 0) begin
                        e_rd[i]++;
                        dlv[i]++;
                    end
                end
            end
        end
    end

    initial begin
        int base [5];
        for (int i = 0; i < 5; i++) begin
            s_wr[i] = 0; s_rd[i] = 0; e_wr[i] = 0; e_rd[i] = 0; dlv[i] = 0; pv[i] = 0; pr[i] = 100;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("reset_payload", i, kd[i], '0);
            chk("reset_valid", i, {39'b0, kv[i]}, '0);
            chk("reset_ready", i, {39'b0, sr[i]}, 40'd1);
        end

        // single write: AW + W, then the slave returns an OKAY response
        for (int i = 0; i < 5; i++) base[i] = dlv[i];
        pv[0] = 100; pv[1] = 100;
        send(0, 40'h1000);
        send(1, {4'hF, 32'hDEAD_BEEF});
        repeat (4) @(posedge clk);
        #2 pv[3] = 100;
        send(3, 40'd0);
        repeat (4) @(posedge clk);
        #2;
        chk("wr_aw_delivered", 0, dlv[0] - base[0], 1);
        chk("wr_w_delivered", 1, dlv[1] - base[1], 1);
        chk("wr_b_delivered", 3, dlv[3] - base[3], 1);
        all_pv(0);

        // back-pressure on AR: ready must drop with two beats held
        pr[2] = 0; pv[2] = 100;
        base[2] = dlv[2];
        for (int k = 0; k < 4; k++) send(2, 40'(4 * k));
        repeat (6) @(posedge clk);
        #2;
        chk("ar_ready_low", 2, {39'b0, sr[2]}, '0);
        pr[2] = 100;
        repeat (8) @(posedge clk);
        #2;
        chk("ar_all_delivered", 2, dlv[2] - base[2], 4);
        pv[2] = 0;

        // throughput: 16 R beats, one per cycle after one cycle of latency
        @(negedge clk);
        #2;
        base[4] = dlv[4];
        for (int k = 0; k < 16; k++) send(4, {6'b0, 2'd2, 32'(k)});
        pv[4] = 100; pr[4] = 100;
        repeat (17) @(posedge clk);
        #1 chk("r_thru_15", 4, dlv[4] - base[4], 15);
        @(posedge clk);
        #1 chk("r_thru_16", 4, dlv[4] - base[4], 16);
        pv[4] = 0;

        // random valid/ready on every channel
        for (int i = 0; i < 5; i++)
            for (int k = 0; k < 1100; k++) send(i, {8'($urandom), 32'($urandom)});
        for (int blk = 0; blk < 10; blk++) begin
            for (int i = 0; i < 5; i++) begin
                pv[i] = $urandom_range(100, 10);
                pr[i] = $urandom_range(100, 10);
            end
            repeat (100) @(posedge clk);
        end
        #2;
        all_pv(0);
        for (int i = 0; i < 5; i++) pr[i] = 100;
        repeat (6) @(posedge clk);
        #2;
        for (int i = 0; i < 5; i++) chk("drained", i, e_wr[i] - e_rd[i], 0);

        // asynchronous reset with two AR beats buffered
        pr[2] = 0; pv[2] = 100;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #2;
        chk("ar_two_buffered", 2, e_wr[2] - e_rd[2], 2);
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("async_rst_valid", i, {39'b0, kv[i]}, '0);
            chk("async_rst_payload", i, kd[i], '0);
            chk("async_rst_ready", i, {39'b0, sr[i]}, 40'd1);
            e_rd[i] = e_wr[i];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        pv[2] = 0; pr[2] = 100;
        repeat (6) @(posedge clk);
        #2;
        for (int i = 0; i < 5; i++) begin
            chk("post_rst_empty", i, e_wr[i] - e_rd[i], 0);
            s_rd[i] = s_wr[i];
        end

        // bypass instance: pure combinational wiring
        send(0, 40'hABCD);
        pv[0] = 100;
        @(posedge clk);
        #2;
        chk("byp_aw_addr", 0, {8'b0, b_out_aw_addr}, 40'hABCD);
        chk("byp_aw_valid", 0, {39'b0, b_out_aw_valid}, 40'd1);
        chk("byp_aw_ready", 0, {39'b0, b_in_aw_ready}, {39'b0, kr[0]});
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 8; k++) send(i, {8'($urandom), 32'($urandom)});
            pv[i] = 50; pr[i] = 50;
        end
        repeat (8) begin
            @(posedge clk);
            #2;
            chk("byp_aw", 0, {7'b0, b_out_aw_valid, b_out_aw_addr}, {7'b0, sv[0], sd[0][31:0]});
            chk("byp_w", 1, {3'b0, b_out_w_valid, b_out_w_strb, b_out_w_data}, {3'b0, sv[1], sd[1][35:0]});
            chk("byp_ar", 2, {7'b0, b_out_ar_valid, b_out_ar_addr}, {7'b0, sv[2], sd[2][31:0]});
            chk("byp_b", 3, {37'b0, b_in_b_valid, b_in_b_resp}, {37'b0, sv[3], sd[3][1:0]});
            chk("byp_r", 4, {5'b0, b_in_r_valid, b_in_r_resp, b_in_r_data}, {5'b0, sv[4], sd[4][33:0]});
            chk("byp_ready", 0, {35'b0, b_in_aw_ready, b_in_w_ready, b_in_ar_ready, b_out_b_ready, b_out_r_ready},
                {35'b0, kr[0], kr[1], kr[2], kr[3], kr[4]});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/axi_lite_reg_cut.md
Name: axi_lite_reg_cut

Overview:
- Pipeline cut for an AXI4-Lite link. Places a fully registered two-entry stage (spill register) on each of the five channels (AW, W, B, AR, R).
- Breaks every combinational path (valid, payload and ready) between the upstream master and the downstream slave.
- Chained instances form multi-cut links for long buses. BYPASS=1 turns the block into a pure wire-through join (zero cuts).

Parameters:
- ADDR_WIDTH, 32, address width of AW/AR; must be >0
- DATA_WIDTH, 32, data width of W/R; must be a multiple of 8; strobe width is DATA_WIDTH/8
- BYPASS, 0, 1 = combinational pass-through of all signals, no registers

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_ni  in  1  asynchronous active-low reset
- in_aw_addr in ADDR_WIDTH; in_aw_valid in 1; in_aw_ready out 1
- in_w_data in DATA_WIDTH; in_w_strb in DATA_WIDTH/8; in_w_valid in 1; in_w_ready out 1
- in_b_resp out 2; in_b_valid out 1; in_b_ready in 1
- in_ar_addr in ADDR_WIDTH; in_ar_valid in 1; in_ar_ready out 1
- in_r_data out DATA_WIDTH; in_r_resp out 2; in_r_valid out 1; in_r_ready in 1
- out_aw_addr out ADDR_WIDTH; out_aw_valid out 1; out_aw_ready in 1
- out_w_data out DATA_WIDTH; out_w_strb out DATA_WIDTH/8; out_w_valid out 1; out_w_ready in 1
- out_b_resp in 2; out_b_valid in 1; out_b_ready out 1
- out_ar_addr out ADDR_WIDTH; out_ar_valid out 1; out_ar_ready in 1
- out_r_data in DATA_WIDTH; out_r_resp in 2; out_r_valid in 1; out_r_ready out 1
- "in" faces the master side; "out" faces the slave side. AW/W/AR flow in->out; B/R flow out->in.

Behaviour:
- Each channel (when BYPASS=0) is one independent spill register with two slots, A (output) and B (overflow), each holding a full flag and a payload.
- Source-side ready = !B.full. This is a registered value, with no combinational dependence on the sink-side ready.
- Sink-side valid = A.full; sink-side payload = A.data. Both are registered.
- Per clock edge:
  - If the sink accepts (valid & ready), A drains.
  - A refills from B if B is full, else from the source if a source handshake occurs in that cycle.
  - If a source handshake occurs while A stays occupied, the beat goes to B.
  - Simultaneous drain + fill is allowed, so full throughput (one beat per cycle) is sustained.
- Latency: a beat accepted at the source in cycle N is presented at the sink in cycle N+1.
- Order is preserved and no beat is dropped or duplicated. At most two beats are buffered per channel.
- Source ready deasserts only when both slots are full. It reasserts the cycle after the sink drains a slot.
- Payload is not modified; the strobe travels with the W data.
- Channels are fully independent. AW/W relative ordering is not enforced, and the block does no protocol checking.
- Reset (rst_ni=0, asynchronous): all slots empty, payload regs 0.
  - All sink-side valids 0 and all payload outputs 0.
  - All source-side readies 1 (B empty).
  - Reset mid-transfer discards any buffered beats.
- Valid must not depend on ready in either direction; the block itself complies.
- BYPASS=1: every out signal equals its in counterpart combinationally, and vice versa. No state; clk_i and rst_ni are unused.
- Elaboration error if DATA_WIDTH%8 != 0.

Test Plan:
- Reset, then idle: out_aw_valid=0, in_aw_ready=1, in_b_valid=0, payloads 0.
- Single write: AW addr 0x1000 plus W data 0xDEADBEEF strb 0xF, slave always ready, B resp 0 returned.
  - out_aw_valid/out_w_valid appear 1 cycle after the handshake with identical payload.
  - in_b_valid appears 1 cycle after out_b handshake, resp 0.
- Back-pressure: stream 4 AR beats (addr 0,4,8,12) with out_ar_ready=0.
  - in_ar_ready drops after 2 accepted beats.
  - On releasing ready, beats emerge in order 0,4,8,12 with no loss.
- Throughput: 16 back-to-back R beats (data = index, resp 2), both sides always ready.
  - One beat per cycle after a 1-cycle initial latency; data 0..15 and resp 2 intact.
- Random valid/ready toggling on all five channels for 1000 cycles, scoreboard per channel: every beat delivered once, in order.
- Asynchronous reset asserted with 2 beats buffered: outputs go to reset values immediately; after release no stale beat emerges.
- BYPASS=1: in_aw_addr=0xABCD, in_aw_valid=1 -> out_aw_addr=0xABCD, out_aw_valid=1 in the same cycle; out_aw_ready reflects combinationally on in_aw_ready.
